// File: rtl/ram_write_loader.sv
// Write-side sequencer for the dual-read-port register RAM.
// Owns the RAM write port: optionally zero-fills addresses 0..MEM_SIZE,
// then streams valid/ready words into consecutive addresses from a base,
// wrapping from MEM_SIZE back to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for iStart; no writes
// S_CLEAR | zero-filling one address per cycle, 0..MEM_SIZE
// S_LOAD  | accepting stream words (oReady=1), one write per accept
// S_DONE  | one-cycle oDone pulse, then back to S_IDLE
module ram_write_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_SIZE   = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic                  iClearFirst,
  input  logic [ADDR_WIDTH-1:0] iBaseAddress,
  input  logic [ADDR_WIDTH:0]   iCount,
  input  logic                  iValid,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oWrap,
  output logic                  oError
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     remain_q, remain_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wrap_q, wrap_d;
  logic                    err_q, err_d;
  logic                    accept;

  assign accept = iValid && (state_q == S_LOAD);

  // Next-state, counter and write-port decisions for the sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    remain_d = remain_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wrap_d   = wrap_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          base_d   = iBaseAddress;
          remain_d = iCount;
          wrap_d   = 1'b0;
          err_d    = 1'b0;
          if (iBaseAddress > ADDR_MAX) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (iClearFirst) begin
            addr_d  = '0;
            state_d = S_CLEAR;
          end else if (iCount == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = iBaseAddress;
            state_d = S_LOAD;
          end
        end
      end

      S_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = '0;
        if (addr_q == ADDR_MAX) begin
          // Load always restarts from the latched base after a clear.
          if (remain_q != '0) begin
            addr_d  = base_q;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end

      S_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = iData;
          if (addr_q == ADDR_MAX) begin
            addr_d = '0;
            wrap_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
          remain_d = (remain_q != '0) ? remain_q - CNT_ONE : '0;
          if (remain_q <= CNT_ONE) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered write port; reset abandons any command.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      remain_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      remain_q <= remain_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign oReady        = (state_q == S_LOAD);
  assign oBusy         = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign oDone         = (state_q == S_DONE);
  assign oWriteEnable  = we_q;
  assign oWriteAddress = waddr_q;
  assign oWriteData    = wdata_q;
  assign oWrap         = wrap_q;
  assign oError        = err_q;

endmodule

// File: tb/tb_ram_write_loader.sv
// Bench for ram_write_loader: a command table run in a loop, with a write
// scoreboard fed by a reference model, plus reset corner-case sequences.
module tb_ram_write_loader;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MS = 10;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iStart = 1'b0;
  logic          iClearFirst = 1'b0;
  logic [AW-1:0] iBaseAddress = '0;
  logic [AW:0]   iCount = '0;
  logic          iValid = 1'b0;
  logic [DW-1:0] iData = '0;
  logic          oReady, oWriteEnable, oBusy, oDone, oWrap, oError;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oWriteData;

  ram_write_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iClearFirst(iClearFirst),
    .iBaseAddress(iBaseAddress), .iCount(iCount), .iValid(iValid), .iData(iData),
    .oReady(oReady), .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
    .oWriteData(oWriteData), .oBusy(oBusy), .oDone(oDone), .oWrap(oWrap),
    .oError(oError)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    bit            clr;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    bit            toggle;
    logic [DW-1:0] d0;
    bit            poke;
    bit            exp_wrap;
    bit            exp_err;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge Clock) begin
    if (oWriteEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write (t=%0t)",
                 oWriteAddress, oWriteData, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(oWriteAddress), 32'(e.a));
        chk("write_data", 32'(oWriteData), 32'(e.d));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int  k, guard, found;
    bit  acc, tog, bad;
    bit  exp_we;
    wr_t w;
    bad    = (int'(v.base) > MS);
    exp_we = !bad && (v.clr || v.cnt != 0);
    @(posedge Clock); #1;
    iStart = 1'b1; iClearFirst = v.clr; iBaseAddress = v.base; iCount = v.cnt;
    if (!bad) begin
      if (v.clr) begin
        for (int i = 0; i <= MS; i++) begin
          w.a = AW'(i); w.d = '0; exp_q.push_back(w);
        end
      end
      for (int i = 0; i < int'(v.cnt); i++) begin
        w.a = AW'((int'(v.base) + i) % (MS + 1));
        w.d = DW'(int'(v.d0) + i);
        exp_q.push_back(w);
      end
    end
    @(posedge Clock); #1;
    iStart = 1'b0;
    k = 0; guard = 0; tog = 1'b1;
    if (!bad) begin
      while (k < int'(v.cnt) && guard < 200) begin
        iValid = v.toggle ? tog : 1'b1;
        iData  = DW'(int'(v.d0) + k);
        if (v.poke && guard == 3) begin
          iStart = 1'b1; iClearFirst = 1'b0; iBaseAddress = AW'(5); iCount = '0;
        end else begin
          iStart = 1'b0;
        end
        @(negedge Clock);
        chk("busy_in_cmd", 32'(oBusy), 32'd1);
        acc = iValid && oReady;
        @(posedge Clock); #1;
        if (acc) k++;
        tog = !tog;
        guard++;
      end
      if (guard >= 200) chk("stream_timeout", 32'(k), 32'(v.cnt));
    end
    iStart = 1'b0; iValid = 1'b0;
    found = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge Clock);
      if (oDone === 1'b1) begin
        found = t;
        break;
      end
      @(posedge Clock); #1;
    end
    if (found < 0) begin
      chk("done_timeout", 32'(oDone), 32'd1);
    end else begin
      chk("we_with_done", 32'(oWriteEnable), 32'(exp_we));
      chk("wrap_at_done", 32'(oWrap), 32'(v.exp_wrap));
      chk("error_at_done", 32'(oError), 32'(v.exp_err));
      if (bad) chk("error_done_delay", 32'(found), 32'd0);
    end
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("done_one_cycle", 32'(oDone), 32'd0);
    chk("idle_not_busy", 32'(oBusy), 32'd0);
    chk("wrap_sticky", 32'(oWrap), 32'(v.exp_wrap));
    chk("error_sticky", 32'(oError), 32'(v.exp_err));
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    //          clr  base     cnt      tog  d0     poke wrap err
    vecs[0] = '{1'b0, 10'd2,   11'd3,  1'b0, 8'hA1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 10'd0,   11'd1,  1'b0, 8'h5C, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 10'd9,   11'd4,  1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 10'd11,  11'd2,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 10'd3,   11'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 10'd5,   11'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 10'd10,  11'd1,  1'b0, 8'h77, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 10'd0,   11'd13, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 10'd1023, 11'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    // Reset held for three cycles, then idle with no commands.
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_we", 32'(oWriteEnable), 32'd0);
    chk("rst_addr", 32'(oWriteAddress), 32'd0);
    chk("rst_data", 32'(oWriteData), 32'd0);
    chk("rst_flags", 32'({oReady, oBusy, oDone, oWrap, oError}), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    repeat (20) begin
      @(negedge Clock);
      chk("idle_no_write", 32'({oWriteEnable, oBusy, oDone}), 32'd0);
    end

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of a five-word load after two words are accepted.
    @(posedge Clock); #1;
    iStart = 1'b1; iClearFirst = 1'b0; iBaseAddress = AW'(4); iCount = (AW+1)'(5);
    exp_q.push_back('{AW'(4), DW'(8'h90)});
    exp_q.push_back('{AW'(5), DW'(8'h91)});
    @(posedge Clock); #1;
    iStart = 1'b0; iValid = 1'b1; iData = 8'h90;
    @(posedge Clock); #1;
    iData = 8'h91;
    @(posedge Clock); #1;
    iValid = 1'b0;
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_we", 32'(oWriteEnable), 32'd0);
    chk("midrst_addr", 32'(oWriteAddress), 32'd0);
    chk("midrst_data", 32'(oWriteData), 32'd0);
    chk("midrst_flags", 32'({oReady, oBusy, oDone, oWrap, oError}), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1; iValid = 1'b1; iData = 8'hEE;
    repeat (10) begin
      @(negedge Clock);
      chk("post_rst_quiet", 32'({oWriteEnable, oReady, oBusy}), 32'd0);
    end
    iValid = 1'b0;
    chk("midrst_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
